// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Two-requester front end for a small 3-bit ALU.  Each requester raises reqK
//   with an opcode and operands; the arbiter picks one winner in IDLE, pulses
//   gntK for the single EXEC cycle, presents the registered result with doneK
//   in DONE, and returns to IDLE once the owner acknowledges with ackK.
//
// Handshake contract:
//   reqK is held high by the requester until it sees gntK.  A request is only
//   accepted in IDLE.  doneK/result are valid from the first DONE cycle until
//   the edge on which the owner's ackK is high; that edge completes the
//   operation.  The non-owner's ack has no effect.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/op0/a0/b0/ack0 requester 0 request, opcode, operands, result accept
//   req1/op1/a1/b1/ack1 requester 1 equivalents
//   gnt0, gnt1          one-cycle grant pulse (EXEC cycle) to the winner
//   done0, done1        result valid for the owning requester
//   result              registered 4-bit ALU result
//   busy                high whenever the FSM is not in IDLE
//   op_count            completed-operation counter, wraps modulo 2^CNT_W
//   state_dbg           current FSM state for observation
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [2:0]       a0,
    input  logic [2:0]       b0,
    input  logic             ack0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [2:0]       a1,
    input  logic [2:0]       b1,
    input  logic             ack1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [3:0]       result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_EQUAL = 2'b10;

    logic [1:0] state;
    logic       ptr;      // requester that wins a tie
    logic       owner;    // requester currently being served
    logic [1:0] cap_op;
    logic [2:0] cap_a;
    logic [2:0] cap_b;

    logic       any_req;
    logic       winner;
    logic       owner_ack;
    logic [3:0] alu_out;
    logic [2:0] sub_diff;

    // A lone request wins outright; a tie goes to the pointer.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ptr : req1;
    end

    always_comb begin
        owner_ack = owner ? ack1 : ack0;
    end

    // 3-bit subtraction wraps naturally, giving (a-b) mod 8.
    always_comb begin
        sub_diff = cap_a - cap_b;
        alu_out  = 4'd0;
        case (cap_op)
            OP_ADD:   alu_out = {1'b0, cap_a} + {1'b0, cap_b};
            OP_SUB:   alu_out = {1'b0, sub_diff};
            OP_EQUAL: alu_out = {1'b0, ~(cap_a ^ cap_b)};
            default:  alu_out = {2'b00, cap_a[2:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cap_op   <= 2'b00;
            cap_a    <= 3'd0;
            cap_b    <= 3'd0;
            result   <= 4'd0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= winner;
                        ptr    <= ~winner;
                        cap_op <= winner ? op1 : op0;
                        cap_a  <= winner ? a1  : a0;
                        cap_b  <= winner ? b1  : b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_out;
                    state  <= DONE;
                end
                DONE: begin
                    if (owner_ack) begin
                        op_count <= op_count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant/done are decoded from state so they can never outlive a reset.
    always_comb begin
        gnt0      = (state == EXEC) && !owner;
        gnt1      = (state == EXEC) &&  owner;
        done0     = (state == DONE) && !owner;
        done1     = (state == DONE) &&  owner;
        busy      = (state != IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed and randomized stimulus for alu_arbiter.  Two instances share the
//   same inputs: the default-width one and a CNT_W=2 one for counter wrap.
//   Expected results come from a plain-arithmetic ALU reference and a simple
//   round-robin / completion-count model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0 = 0, req1 = 0, ack0 = 0, ack1 = 0;
    logic [1:0] op0 = 0, op1 = 0;
    logic [2:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;

    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] result;
    logic [7:0] op_count;
    logic [1:0] state_dbg;

    logic       gnt0_w, gnt1_w, done0_w, done1_w, busy_w;
    logic [3:0] result_w;
    logic [1:0] op_count_w;
    logic [1:0] state_dbg_w;

    alu_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
    );

    alu_arbiter #(.CNT_W(2)) u_dut_w (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
        .gnt0(gnt0_w), .gnt1(gnt1_w), .done0(done0_w), .done1(done1_w),
        .result(result_w), .busy(busy_w), .op_count(op_count_w), .state_dbg(state_dbg_w)
    );

    // ---------------- scoreboard / model ----------------
    logic [3:0] exp_q[$];
    int total_cnt = 0;
    int pass_cnt  = 0;
    int model_ptr   = 0;
    int model_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        int r;
        case (op)
            0: return a + b;
            1: return (a - b + 8) % 8;
            2: begin
                r = 0;
                for (int i = 0; i < 3; i++)
                    if (((a >> i) & 1) == ((b >> i) & 1)) r += (1 << i);
                return r;
            end
            default: return a / 2;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int op, input int a, input int b);
        if (k == 0) begin
            req0 = 1; op0 = op[1:0]; a0 = a[2:0]; b0 = b[2:0];
        end else begin
            req1 = 1; op1 = op[1:0]; a1 = a[2:0]; b1 = b[2:0];
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  busy,  0);
        check({tag, "_gnt"},   {gnt0, gnt1}, 0);
        check({tag, "_done"},  {done0, done1}, 0);
        check({tag, "_cnt"},   op_count, model_count % 256);
        check({tag, "_cnt_w"}, op_count_w, model_count % 4);
        check({tag, "_busy_w"}, {busy_w, gnt0_w, gnt1_w, done0_w, done1_w}, 0);
    endtask

    // Called in an IDLE cycle with requests already driven; runs one full
    // operation, holding the owner's ack off for `hold` cycles while the
    // other requester's ack toggles.
    task automatic serve_one(input int hold, output int w);
        logic [3:0] exp_res;
        if (req0 && req1) w = model_ptr;
        else w = req1 ? 1 : 0;
        if (w == 0) exp_q.push_back(4'(alu_ref(op0, a0, b0)));
        else        exp_q.push_back(4'(alu_ref(op1, a1, b1)));
        tick();
        check("exec_gnt0", gnt0, w == 0);
        check("exec_gnt1", gnt1, w == 1);
        check("exec_busy", busy, 1);
        check("exec_done", {done0, done1}, 0);
        if (w == 0) req0 = 0; else req1 = 0;
        model_ptr = 1 - w;
        tick();
        exp_res = exp_q.pop_front();
        check("done_gnt", {gnt0, gnt1}, 0);
        check("done_owner", w ? done1 : done0, 1);
        check("done_other", w ? done0 : done1, 0);
        check("done_result", result, exp_res);
        check("done_result_w", result_w, exp_res);
        for (int i = 0; i < hold; i++) begin
            if (w == 0) ack1 = (i % 2 == 0); else ack0 = (i % 2 == 0);
            tick();
            check("hold_done", {done0, done1}, w ? 2'b01 : 2'b10);
            check("hold_result", result, exp_res);
            check("hold_cnt", op_count, model_count % 256);
        end
        ack0 = 0; ack1 = 0;
        if (w == 0) ack0 = 1; else ack1 = 1;
        tick();
        ack0 = 0; ack1 = 0;
        model_count++;
        check_quiet("ack");
        check("ack_result_kept", result, exp_res);
    endtask

    task automatic reset_mid(input int in_done);
        set_req(0, 0, 3, 3);
        tick();
        check("rst_pre_gnt0", gnt0, 1);
        if (in_done) begin
            req0 = 0;
            tick();
            check("rst_pre_done0", done0, 1);
            req0 = 1;
        end
        rst = 1;
        ack0 = 1;
        tick();
        rst = 0; req0 = 0; ack0 = 0;
        model_ptr = 0; model_count = 0;
        check_quiet("rst_mid");
        check("rst_mid_result", result, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_after_done", {done0, done1, busy}, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int pat;
        rst = 1;
        tick(); tick();
        check_quiet("reset");
        check("reset_result", result, 0);
        rst = 0;
        tick();

        // lone request, add 5+6
        set_req(0, 0, 5, 6);
        serve_one(0, w);
        check("lone_result", result, 4'b1011);
        check("lone_cnt", op_count, 1);

        // tie after reset: requester 0 first, then requester 1
        rst = 1; tick(); rst = 0; model_ptr = 0; model_count = 0;
        set_req(0, 1, 2, 5);
        set_req(1, 3, 7, 0);
        serve_one(1, w);
        check("tie_first", w, 0);
        check("tie_result0", result, 4'b0101);
        serve_one(0, w);
        check("tie_second", w, 1);
        check("tie_result1", result, 4'b0011);

        // equal op on requester 1
        set_req(1, 2, 5, 4);
        serve_one(0, w);
        check("equal_result", result, 4'b0110);

        // ack hold-off with foreign ack pulses
        set_req(0, 0, 7, 7);
        serve_one(5, w);
        check("holdoff_result", result, 14);

        // resets mid-operation, with requests and ack held through rst
        reset_mid(0);
        reset_mid(1);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            pat = $urandom_range(1, 3);
            if (pat[0]) set_req(0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
            if (pat[1]) set_req(1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
            serve_one($urandom_range(0, 3), w);
            if (pat == 3) serve_one($urandom_range(0, 3), w);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
